cache_plru_state_array: RTL
===========================

Name: cache_plru_state_array

Overview:
- Per-set PLRU state store placed directly upstream of the PLRU replacement-algorithm block; also consumes that block's updated bits.
- For each cache lookup it reads the set's WAYS-1 tree bits and presents them, with hit/way info, to the replacement block.
- It writes back the returned updated bits and reports the selected way to the cache controller.
- It owns state initialisation on reset and flush, and handles read-after-write hazards between back-to-back lookups.

Parameters:
- WAYS, 8, associativity; tree holds WAYS-1 bits.
- WAYS_REP, 3, way encoding width (log2 WAYS).
- SETS, 16384, number of sets.
- INDEX_BITS, 14, set index width (log2 SETS).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  one-cycle pulse; re-initialises all sets.
- req_valid  in  1  lookup request.
- req_ready  out  1  block can accept a request.
- req_index  in  INDEX_BITS  set index.
- req_hit  in  1  lookup hit.
- req_hit_way  in  WAYS_REP  hitting way (valid when req_hit=1).
- plru_cur  out  WAYS-1  to replacement block plru_in.
- cmpr_read_hit  out  1  to replacement block.
- way_read_hit  out  WAYS_REP  to replacement block.
- plru_next  in  WAYS-1  from replacement block plru_out.
- way_sel  in  WAYS_REP  from replacement block ways.
- rsp_valid  out  1  response strobe.
- rsp_way  out  WAYS_REP  way touched (hit) or victim (miss).
- init_busy  out  1  initialisation sweep in progress.

Behaviour:
- Storage: SETS x (WAYS-1) array, not directly reset. Contents are cleared by the sweep.
- FSM states:
  - INIT: clear one set per cycle; counter runs 0..SETS-1; req_ready=0; init_busy=1.
  - RUN: normal operation; req_ready=1; init_busy=0.
- FSM transitions:
  - rst_n=0 forces INIT with counter=0.
  - INIT -> RUN the cycle after set SETS-1 is written; sweep lasts exactly SETS cycles.
  - flush in RUN -> INIT with counter=0. Any request accepted in that same cycle is dropped: no rsp_valid, no write.
  - flush during INIT restarts the counter at 0.
- Reset values: req_ready=0, init_busy=1, rsp_valid=0, rsp_way=0, plru_cur=0, cmpr_read_hit=0, way_read_hit=0, stage-1 valid=0.
- Pipeline, with a request accepted at cycle T (req_valid & req_ready):
  - Edge ending T captures into stage 1: index, hit, hit_way, and array[index].
  - Cycle T+1: stage 1 drives plru_cur, cmpr_read_hit, way_read_hit. The replacement block responds combinationally.
  - Edge ending T+1 writes plru_next into array[index], registers rsp_way=way_sel, and sets rsp_valid=1 for cycle T+2.
  - Latency is 2 cycles request-to-response; throughput is 1 request per cycle.
- When stage 1 is invalid, plru_cur, cmpr_read_hit and way_read_hit drive 0. The replacement block's write is suppressed.
- Hazard: if the request at T uses the same index as the stage-1 entry being written at T, stage 1 captures plru_next (forwarded), not the stale array value. Different indices need no forwarding.
- req_hit_way is ignored when req_hit=0.
- rst_n deasserted mid-operation: the in-flight stage-1 entry is discarded; no response; no array write.

Optional Feature:
- Macro: PLRU_STATS_EN.
- Defined: adds outputs hit_count[31:0] and miss_count[31:0].
  - Each counter increments on the rsp_valid cycle according to that response's hit flag.
  - Counters saturate at 32'hFFFF_FFFF.
  - Both clear on rst_n=0 or flush.
- Undefined: no counters and no extra ports; behaviour otherwise identical.

Test Plan:
- Reset with SETS=16: rst_n low 2 cycles then high -> init_busy=1 and req_ready=0 for exactly 16 cycles, then req_ready=1.
- Miss on index 5 after init -> plru_cur=7'h00 in cycle T+1; rsp_valid in T+2 with rsp_way = model(7'h00) victim; array[5] = model update.
- Hit on index 3, way 6 -> cmpr_read_hit=1 and way_read_hit=3'd6 in T+1; rsp_way=3'd6; array[3] = model update of 7'h00 with way 6.
- Back-to-back: hit way 2 on index 9, then miss on index 9 next cycle -> second plru_cur equals the first plru_next (forwarded); the second victim differs from the unforwarded case.
- Flush pulsed in the same cycle as an accepted request -> no rsp_valid for it; 16-cycle sweep; all sets read back 7'h00.
- With PLRU_STATS_EN defined: 3 hits + 2 misses -> hit_count=3, miss_count=2; flush -> both 0.

Source files
------------

// File: rtl/cache_plru_state_array.sv
// ----------------------------------------------------------------------------
// cache_plru_state_array
//
// Purpose:
//   Per-set tree-PLRU state store that sits directly in front of the PLRU
//   replacement block. For every lookup it reads the set's WAYS-1 tree bits
//   and presents them to the replacement block. It then writes back the
//   updated bits that block returns, and reports the touched/victim way to
//   the cache controller. It also clears every set after reset and after a
//   flush, and forwards freshly written bits to a back-to-back lookup of the
//   same set.
//
// Ports:
//   clk, rst_n        clock (rising edge), synchronous active-low reset
//   flush             one-cycle pulse, re-initialises all sets
//   req_valid/ready   lookup handshake
//   req_index         set index of the lookup
//   req_hit/hit_way   lookup hit flag and hitting way
//   plru_cur          tree bits to the replacement block (plru_in)
//   cmpr_read_hit     hit flag to the replacement block
//   way_read_hit      hitting way to the replacement block
//   plru_next         updated tree bits from the replacement block
//   way_sel           selected way from the replacement block
//   rsp_valid/rsp_way response strobe and touched/victim way
//   init_busy         initialisation sweep in progress
//   hit_count/miss_count  (PLRU_STATS_EN only) saturating response counters
//
// Configuration:
//   PLRU_STATS_EN  when defined, adds the hit_count/miss_count outputs.
// ----------------------------------------------------------------------------
module cache_plru_state_array #(
    parameter int WAYS       = 8,
    parameter int WAYS_REP   = 3,
    parameter int SETS       = 16384,
    parameter int INDEX_BITS = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [INDEX_BITS-1:0] req_index,
    input  logic                  req_hit,
    input  logic [WAYS_REP-1:0]   req_hit_way,
    output logic [WAYS-2:0]       plru_cur,
    output logic                  cmpr_read_hit,
    output logic [WAYS_REP-1:0]   way_read_hit,
    input  logic [WAYS-2:0]       plru_next,
    input  logic [WAYS_REP-1:0]   way_sel,
    output logic                  rsp_valid,
    output logic [WAYS_REP-1:0]   rsp_way,
    output logic                  init_busy
`ifdef PLRU_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [INDEX_BITS-1:0]  init_cnt;
    logic [INDEX_BITS-1:0]  init_cnt_nxt;

    logic [WAYS-2:0]        plru_mem [SETS];
    logic                   mem_we;
    logic [INDEX_BITS-1:0]  mem_waddr;
    logic [WAYS-2:0]        mem_wdata;

    logic                   accept;
    logic [WAYS-2:0]        rd_data;

    logic                   s1_valid;
    logic [INDEX_BITS-1:0]  s1_index;
    logic                   s1_hit;
    logic [WAYS_REP-1:0]    s1_hit_way;
    logic [WAYS-2:0]        s1_plru;

    // State register for the init/run controller. Reset always restarts the
    // sweep from set 0 so the array never needs a reset of its own.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_cnt_nxt;
        end
    end

    // Next-state logic. The sweep clears one set per cycle and hands over to
    // RUN right after the last set is written. A flush in either state
    // restarts the sweep from set 0.
    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        case (state)
            ST_INIT: begin
                if (flush) begin
                    init_cnt_nxt = '0;
                end else if (init_cnt == INDEX_BITS'(SETS - 1)) begin
                    state_nxt    = ST_RUN;
                    init_cnt_nxt = '0;
                end else begin
                    init_cnt_nxt = init_cnt + INDEX_BITS'(1);
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_nxt    = ST_INIT;
                    init_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt    = ST_INIT;
                init_cnt_nxt = '0;
            end
        endcase
    end

    assign req_ready = (state == ST_RUN);
    assign init_busy = (state == ST_INIT);

    // A request presented together with flush is dropped entirely.
    assign accept = req_valid & req_ready & ~flush;

    // The single array write port is shared by the sweep and the pipeline.
    // Stage 1 is never valid during INIT, so the two never collide. Holding
    // reset blocks the write so an in-flight update is discarded.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = init_cnt;
        mem_wdata = '0;
        if (rst_n) begin
            if (state == ST_INIT) begin
                mem_we = 1'b1;
            end else if (s1_valid) begin
                mem_we    = 1'b1;
                mem_waddr = s1_index;
                mem_wdata = plru_next;
            end
        end
    end

    // Array storage with no reset; its contents come only from the sweep
    // and from pipeline write-backs.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            plru_mem[mem_waddr] <= mem_wdata;
        end
    end

    // When the new lookup targets the set being written this cycle, the
    // array still holds the old bits, so take the replacement block's
    // result directly.
    assign rd_data = (s1_valid && (s1_index == req_index)) ? plru_next
                                                           : plru_mem[req_index];

    // Stage 1 holds the accepted lookup for the cycle in which the
    // replacement block evaluates it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_index   <= '0;
            s1_hit     <= 1'b0;
            s1_hit_way <= '0;
            s1_plru    <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_index   <= req_index;
                s1_hit     <= req_hit;
                s1_hit_way <= req_hit ? req_hit_way : '0;
                s1_plru    <= rd_data;
            end
        end
    end

    assign plru_cur      = s1_valid ? s1_plru : '0;
    assign cmpr_read_hit = s1_valid & s1_hit;
    assign way_read_hit  = s1_valid ? s1_hit_way : '0;

    // Response register: the way the replacement block chose for the
    // stage-1 lookup, presented one cycle later to the cache controller.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_way   <= '0;
        end else begin
            rsp_valid <= s1_valid;
            if (s1_valid) begin
                rsp_way <= way_sel;
            end
        end
    end

`ifdef PLRU_STATS_EN
    logic rsp_hit;

    // Hit flag travelling alongside the response so the counters know which
    // one to bump.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_hit <= 1'b0;
        end else if (s1_valid) begin
            rsp_hit <= s1_hit;
        end
    end

    // Saturating hit/miss counters, cleared by reset or flush. A flush
    // takes priority over a response in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (rsp_valid) begin
            if (rsp_hit) begin
                if (hit_count != 32'hFFFF_FFFF) begin
                    hit_count <= hit_count + 32'd1;
                end
            end else begin
                if (miss_count != 32'hFFFF_FFFF) begin
                    miss_count <= miss_count + 32'd1;
                end
            end
        end
    end
`endif

endmodule
